// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM responder: FSM encoding,
// big-endian byte-lane positions and latency limits.
package dsram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Offset 00 is the most significant byte and is enabled by wen[3].
    localparam int LANE0_MSB = 31;
    localparam int LANE0_LSB = 24;
    localparam int LANE1_MSB = 23;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_MSB = 15;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_MSB = 7;
    localparam int LANE3_LSB = 0;

    localparam logic [3:0] WEN_READ    = 4'b0000;
    localparam int         LATENCY_MAX = 15;

    function automatic int clamp_latency(input int lat);
        if (lat < 1)
            return 1;
        else if (lat > LATENCY_MAX)
            return LATENCY_MAX;
        else
            return lat;
    endfunction

    // Word seen after the enabled lanes of wdata are written over old_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        if (wen[3]) merged[LANE0_MSB:LANE0_LSB] = wdata[LANE0_MSB:LANE0_LSB];
        if (wen[2]) merged[LANE1_MSB:LANE1_LSB] = wdata[LANE1_MSB:LANE1_LSB];
        if (wen[1]) merged[LANE2_MSB:LANE2_LSB] = wdata[LANE2_MSB:LANE2_LSB];
        if (wen[0]) merged[LANE3_MSB:LANE3_LSB] = wdata[LANE3_MSB:LANE3_LSB];
        return merged;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Single-port word RAM with per-byte write enables and a registered,
// write-first read port, shaped for block-RAM inference.
module byte_lane_ram
    import dsram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // NOTE: storage has no reset so it maps onto block RAM; contents
    // survive rst, which lets a committed write outlive an aborted response.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_wen[3]) r_mem[i_addr][LANE0_MSB:LANE0_LSB] <= i_wdata[LANE0_MSB:LANE0_LSB];
            if (i_wen[2]) r_mem[i_addr][LANE1_MSB:LANE1_LSB] <= i_wdata[LANE1_MSB:LANE1_LSB];
            if (i_wen[1]) r_mem[i_addr][LANE2_MSB:LANE2_LSB] <= i_wdata[LANE2_MSB:LANE2_LSB];
            if (i_wen[0]) r_mem[i_addr][LANE3_MSB:LANE3_LSB] <= i_wdata[LANE3_MSB:LANE3_LSB];
            r_rdata <= merge_lanes(r_mem[i_addr], i_wdata, i_wen);
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the data SRAM interface: one outstanding request,
// full-word response a fixed number of edges after acceptance.
module data_sram_resp
    import dsram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_data_ok,
    output logic        data_sram_busy
);

    localparam int         LAT    = clamp_latency(LATENCY);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_count;
    logic [3:0]        w_next_count;
    logic [ADDR_W-1:0] r_index;
    logic              w_accept;
    logic              w_busy;
    logic              w_ok;
    logic              w_ram_en;
    logic [3:0]        w_ram_wen;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_q;
    logic              w_unused_addr_bits;

    assign w_unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // NOTE: every output of this block gets a default first, so no path
    // through the case can infer a latch; an illegal state falls to IDLE.
    always_comb begin
        w_next_state = IDLE;
        w_next_count = '0;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_ok         = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                w_ok     = (r_state == RESP);
                w_accept = data_sram_en && !rst;
                if (w_accept) begin
                    w_next_state = (LAT == 1) ? RESP : WAIT;
                    w_next_count = (LAT == 1) ? 4'd0 : LAT_M1;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (r_count == 4'd1) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                    w_next_count = r_count - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // The RAM port writes at acceptance and reads on the edge entering RESP;
    // those two never need different addresses on the same edge.
    assign w_ram_en   = w_accept || (r_state == WAIT && r_count == 4'd1);
    assign w_ram_wen  = w_accept ? data_sram_wen : WEN_READ;
    assign w_ram_addr = w_accept ? data_sram_addr[ADDR_W+1:2] : r_index;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_accept)
                r_index <= data_sram_addr[ADDR_W+1:2];
        end
    end

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_wen   (w_ram_wen),
        .i_addr  (w_ram_addr),
        .i_wdata (data_sram_wdata),
        .o_rdata (w_ram_q)
    );

    assign data_sram_data_ok = w_ok;
    assign data_sram_busy    = w_busy;
    assign data_sram_rdata   = w_ok ? w_ram_q : 32'h0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: three instances at LATENCY 1, 3 and 4
// driven from vector tables and hand-written handshake/reset sequences.
module tb_data_sram_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en1, en3, en4;
    logic [3:0]  wen1, wen3, wen4;
    logic [31:0] addr1, addr3, addr4;
    logic [31:0] wdata1, wdata3, wdata4;
    logic [31:0] rdata1, rdata3, rdata4;
    logic        ok1, ok3, ok4;
    logic        busy1, busy3, busy4;

    data_sram_resp #(.ADDR_W(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .data_sram_en(en1), .data_sram_wen(wen1),
        .data_sram_addr(addr1), .data_sram_wdata(wdata1), .data_sram_rdata(rdata1),
        .data_sram_data_ok(ok1), .data_sram_busy(busy1));

    data_sram_resp #(.ADDR_W(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .data_sram_data_ok(ok3), .data_sram_busy(busy3));

    data_sram_resp #(.ADDR_W(10), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .data_sram_en(en4), .data_sram_wen(wen4),
        .data_sram_addr(addr4), .data_sram_wdata(wdata4), .data_sram_rdata(rdata4),
        .data_sram_data_ok(ok4), .data_sram_busy(busy4));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ok;
        logic        exp_busy;
        logic        chk_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n;
        logic [6:0] exp_busy3;
        logic [6:0] exp_ok3;

        // LATENCY=1: each accepted request is answered in the very next cycle.
        vecs[0]  = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'b1111, 32'h0000_0020, 32'h0102_0304, 1'b1, 1'b0, 1'b1, 32'h0102_0304};
        vecs[2]  = '{1'b1, 4'b1000, 32'h0000_0020, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b1, 32'hAA02_0304};
        vecs[3]  = '{1'b1, 4'b0001, 32'h0000_0023, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'hAA02_0355};
        vecs[4]  = '{1'b1, 4'b0000, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 1'b1, 32'hAA02_0355};
        vecs[5]  = '{1'b0, 4'b0000, 32'h0000_0020, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 4'b1111, 32'h0000_0040, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 32'h1122_3344};
        vecs[7]  = '{1'b1, 4'b0011, 32'h0000_0042, 32'hBEEF_BEEF, 1'b1, 1'b0, 1'b1, 32'h1122_BEEF};
        vecs[8]  = '{1'b1, 4'b0000, 32'h0000_0040, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1122_BEEF};
        vecs[9]  = '{1'b1, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 4'b0000, 32'h0000_0004, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 4'b0100, 32'h0000_0005, 32'h7777_7777, 1'b1, 1'b0, 1'b1, 32'hDE77_BEEF};
        vecs[12] = '{1'b1, 4'b0000, 32'hFFFF_1006, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDE77_BEEF};
        vecs[13] = '{1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h0};

        en1 = 0; wen1 = 0; addr1 = 0; wdata1 = 0;
        en3 = 0; wen3 = 0; addr3 = 0; wdata3 = 0;
        en4 = 0; wen4 = 0; addr4 = 0; wdata4 = 0;

        // Reset state on all instances.
        repeat (2) @(posedge clk);
        #1;
        check("rst_l1_ok",    32'(ok1),    32'h0);
        check("rst_l1_busy",  32'(busy1),  32'h0);
        check("rst_l1_rdata", rdata1,      32'h0);
        check("rst_l3_ok",    32'(ok3),    32'h0);
        check("rst_l3_busy",  32'(busy3),  32'h0);
        check("rst_l3_rdata", rdata3,      32'h0);
        check("rst_l4_ok",    32'(ok4),    32'h0);
        check("rst_l4_busy",  32'(busy4),  32'h0);
        check("rst_l4_rdata", rdata4,      32'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            en1 = vecs[i].en; wen1 = vecs[i].wen; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ok", i),   32'(ok1),   32'(vecs[i].exp_ok));
            check($sformatf("v%0d_busy", i), 32'(busy1), 32'(vecs[i].exp_busy));
            if (vecs[i].chk_data)
                check($sformatf("v%0d_rdata", i), rdata1, vecs[i].exp_rdata);
        end

        // LATENCY=3: seed a word, then hold en for five cycles of reads.
        @(negedge clk);
        en3 = 1; wen3 = 4'b1111; addr3 = 32'h0000_0010; wdata3 = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        @(negedge clk);
        en3 = 0; wen3 = 4'b0000;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (ok3) begin
                n = k;
                break;
            end
        end
        check("l3_wr_latency", 32'(n), 32'd2);
        check("l3_wr_rdata",   rdata3, 32'h1357_9BDF);

        exp_busy3 = 7'b0011011;   // bit k = expected busy after edge k
        exp_ok3   = 7'b0100100;
        @(negedge clk);
        en3 = 1; wen3 = 4'b0000; addr3 = 32'h0000_0010; wdata3 = 32'hFFFF_FFFF;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("l3_hs%0d_busy", k), 32'(busy3), 32'(exp_busy3[k]));
            check($sformatf("l3_hs%0d_ok", k),   32'(ok3),   32'(exp_ok3[k]));
            if (exp_ok3[k])
                check($sformatf("l3_hs%0d_rdata", k), rdata3, 32'h1357_9BDF);
            if (k == 4) begin
                @(negedge clk);
                en3 = 0;
            end
        end

        // LATENCY=4: reset two cycles into a write; no response, write kept.
        @(negedge clk);
        en4 = 1; wen4 = 4'b1111; addr4 = 32'h0000_0080; wdata4 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("l4_acc_busy", 32'(busy4), 32'h1);
        @(negedge clk);
        en4 = 0; wen4 = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check("l4_rst_ok",    32'(ok4),   32'h0);
        check("l4_rst_busy",  32'(busy4), 32'h0);
        check("l4_rst_rdata", rdata4,     32'h0);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("l4_no_ok%0d", k), 32'(ok4), 32'h0);
        end

        @(negedge clk);
        en4 = 1; wen4 = 4'b0000; addr4 = 32'h0000_0080; wdata4 = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        en4 = 0;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (ok4) begin
                n = k;
                break;
            end
        end
        check("l4_rd_latency", 32'(n), 32'd3);
        check("l4_rd_rdata",   rdata4, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
